// File: rtl/lsu_pkg.sv
// lsu_pkg: op, exception and state encodings plus the bus payload shared by
// the load/store bus master and its lane helper.
package lsu_pkg;

  localparam int unsigned XLEN  = 32;
  localparam int unsigned CNT_W = 16;

  localparam logic [2:0] OP_LW  = 3'b000;
  localparam logic [2:0] OP_LH  = 3'b001;
  localparam logic [2:0] OP_LHU = 3'b010;
  localparam logic [2:0] OP_LB  = 3'b011;
  localparam logic [2:0] OP_LBU = 3'b100;
  localparam logic [2:0] OP_SW  = 3'b101;
  localparam logic [2:0] OP_SH  = 3'b110;
  localparam logic [2:0] OP_SB  = 3'b111;

  localparam logic [1:0] EXC_NONE     = 2'd0;
  localparam logic [1:0] EXC_MISALIGN = 2'd1;
  localparam logic [1:0] EXC_RANGE    = 2'd2;
  localparam logic [1:0] EXC_TIMEOUT  = 2'd3;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_BUSY = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  typedef struct packed {
    logic            we;
    logic [XLEN-1:0] addr;
    logic [3:0]      be;
    logic [XLEN-1:0] wdata;
  } bus_req_t;

  function automatic logic is_store(input logic [2:0] op);
    return op[2] & (op[1] | op[0]);
  endfunction

endpackage

// File: rtl/lsu_lane.sv
// lsu_lane: byte-enable generation and write-lane replication for the request,
// and half/byte extraction with sign/zero extension for the returned word.
module lsu_lane
  import lsu_pkg::*;
(
  input  logic [2:0]      st_op,
  input  logic [1:0]      st_off,
  input  logic [XLEN-1:0] st_wdata,
  output logic [3:0]      be_c,
  output logic [XLEN-1:0] wdata_c,
  input  logic [2:0]      ld_op,
  input  logic [1:0]      ld_off,
  input  logic [XLEN-1:0] ld_word,
  output logic [XLEN-1:0] rdata_c
);

  logic [15:0] half_c;
  logic [7:0]  byte_c;

  // Loads always request the full word; only stores narrow the enables.
  always_comb begin
    be_c    = 4'b1111;
    wdata_c = '0;
    case (st_op)
      OP_SW: wdata_c = st_wdata;
      OP_SH: begin
        be_c    = st_off[1] ? 4'b1100 : 4'b0011;
        wdata_c = {2{st_wdata[15:0]}};
      end
      OP_SB: begin
        be_c    = 4'b0001 << st_off;
        wdata_c = {4{st_wdata[7:0]}};
      end
      default: begin end
    endcase
  end

  always_comb begin
    half_c = ld_off[1] ? ld_word[31:16] : ld_word[15:0];
    byte_c = ld_word[7:0];
    case (ld_off)
      2'd1:    byte_c = ld_word[15:8];
      2'd2:    byte_c = ld_word[23:16];
      2'd3:    byte_c = ld_word[31:24];
      default: byte_c = ld_word[7:0];
    endcase
    rdata_c = '0;
    case (ld_op)
      OP_LW:   rdata_c = ld_word;
      OP_LH:   rdata_c = {{16{half_c[15]}}, half_c};
      OP_LHU:  rdata_c = {16'h0000, half_c};
      OP_LB:   rdata_c = {{24{byte_c[7]}}, byte_c};
      OP_LBU:  rdata_c = {24'h000000, byte_c};
      default: rdata_c = '0;
    endcase
  end

endmodule

// File: rtl/lsu_bus_master.sv
// lsu_bus_master: MEM-stage load/store initiator on a word-addressed,
// byte-enabled data bus. Optional LSU_TRACE_EN prints stores and exceptions.
module lsu_bus_master
  import lsu_pkg::*;
#(
  parameter logic [XLEN-1:0] MEM_LO  = 32'h0000_0000,
  parameter logic [XLEN-1:0] MEM_HI  = 32'h0000_2fff,
  parameter int unsigned     TIMEOUT = 255
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            req_valid,
  input  logic [2:0]      op,
  input  logic [XLEN-1:0] addr,
  input  logic [XLEN-1:0] wdata,
  output logic            stall,
  output logic            done,
  output logic [XLEN-1:0] rdata,
  output logic            exc,
  output logic [1:0]      exc_code,
  output logic            mem_req,
  output logic            mem_we,
  output logic [XLEN-1:0] mem_addr,
  output logic [3:0]      mem_be,
  output logic [XLEN-1:0] mem_wdata,
  input  logic            mem_ack,
  input  logic [XLEN-1:0] mem_rdata
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  logic [1:0]      state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  bus_req_t        bus_q, bus_d;
  logic            req_q, req_d;
  logic [2:0]      op_q, op_d;
  logic [1:0]      off_q, off_d;
  logic            done_q, done_d;
  logic            exc_q, exc_d;
  logic [1:0]      code_q, code_d;
  logic [XLEN-1:0] rdata_q, rdata_d;

  logic            misalign_c, range_err_c;
  logic [3:0]      be_c;
  logic [XLEN-1:0] wrep_c, rext_c;

  always_comb begin
    misalign_c = 1'b0;
    case (op)
      OP_LW, OP_SW:         misalign_c = (addr[1:0] != 2'b00);
      OP_LH, OP_LHU, OP_SH: misalign_c = addr[0];
      default:              misalign_c = 1'b0;
    endcase
  end

  // Single unsigned compare: addresses below MEM_LO wrap to a large offset.
  assign range_err_c = (addr - MEM_LO) > (MEM_HI - MEM_LO);

  lsu_lane u_lane (
    .st_op    (op),
    .st_off   (addr[1:0]),
    .st_wdata (wdata),
    .be_c     (be_c),
    .wdata_c  (wrep_c),
    .ld_op    (op_q),
    .ld_off   (off_q),
    .ld_word  (mem_rdata),
    .rdata_c  (rext_c)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bus_d   = bus_q;
    bus_d.we = 1'b0;
    req_d   = 1'b0;
    op_d    = op_q;
    off_d   = off_q;
    done_d  = 1'b0;
    exc_d   = 1'b0;
    code_d  = EXC_NONE;
    rdata_d = '0;
    case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if (req_valid) begin
          if (misalign_c || range_err_c) begin
            state_d = S_DONE;
            done_d  = 1'b1;
            exc_d   = 1'b1;
            code_d  = misalign_c ? EXC_MISALIGN : EXC_RANGE;
          end else begin
            state_d    = S_BUSY;
            req_d      = 1'b1;
            bus_d.we   = is_store(op);
            bus_d.addr = {addr[XLEN-1:2], 2'b00};
            bus_d.be   = be_c;
            bus_d.wdata = wrep_c;
            op_d       = op;
            off_d      = addr[1:0];
          end
        end
      end
      S_BUSY: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (mem_ack) begin
          state_d = S_DONE;
          done_d  = 1'b1;
          rdata_d = rext_c;
        end else if (cnt_q == CNT_LAST) begin
          state_d = S_DONE;
          done_d  = 1'b1;
          exc_d   = 1'b1;
          code_d  = EXC_TIMEOUT;
        end else begin
          req_d    = 1'b1;
          bus_d.we = bus_q.we;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      bus_q   <= '0;
      req_q   <= 1'b0;
      op_q    <= OP_LW;
      off_q   <= '0;
      done_q  <= 1'b0;
      exc_q   <= 1'b0;
      code_q  <= EXC_NONE;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bus_q   <= bus_d;
      req_q   <= req_d;
      op_q    <= op_d;
      off_q   <= off_d;
      done_q  <= done_d;
      exc_q   <= exc_d;
      code_q  <= code_d;
      rdata_q <= rdata_d;
    end
  end

  assign stall     = ((state_q == S_IDLE) && req_valid) || (state_q == S_BUSY);
  assign done      = done_q;
  assign rdata     = rdata_q;
  assign exc       = exc_q;
  assign exc_code  = code_q;
  assign mem_req   = req_q;
  assign mem_we    = bus_q.we;
  assign mem_addr  = bus_q.addr;
  assign mem_be    = bus_q.be;
  assign mem_wdata = bus_q.wdata;

`ifdef LSU_TRACE_EN
  logic [XLEN-1:0] merged_c;

  always_comb begin
    for (int i = 0; i < 4; i++)
      merged_c[8*i +: 8] = bus_q.be[i] ? bus_q.wdata[8*i +: 8] : mem_rdata[8*i +: 8];
  end

  always_ff @(posedge clk) begin
    if (!reset && (state_q == S_BUSY) && mem_ack && bus_q.we)
      $display("[LSU] %0t store addr=%08h word=%08h", $time, bus_q.addr, merged_c);
    if (!reset && exc_d)
      $display("[LSU] %0t exception code=%0d addr=%08h", $time, code_d,
               (state_q == S_IDLE) ? addr : bus_q.addr);
  end
`endif

endmodule

// File: tb/tb_lsu_bus_master.sv
// tb_lsu_bus_master: random and directed load/store traffic against a
// transaction-level model of the bus master, checked every cycle.
module tb_lsu_bus_master;
  import lsu_pkg::*;

  localparam logic [31:0] TB_LO = 32'h0000_0000;
  localparam logic [31:0] TB_HI = 32'h0000_2fff;
  localparam int unsigned TB_TO = 4;

  logic        clk = 1'b0;
  logic        reset, req_valid, mem_ack;
  logic [2:0]  op;
  logic [31:0] addr, wdata, mem_rdata;
  logic        stall, done, exc, mem_req, mem_we;
  logic [1:0]  exc_code;
  logic [31:0] rdata, mem_addr, mem_wdata;
  logic [3:0]  mem_be;

  always #5 clk = ~clk;

  lsu_bus_master #(.MEM_LO(TB_LO), .MEM_HI(TB_HI), .TIMEOUT(TB_TO)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .op(op), .addr(addr),
    .wdata(wdata), .stall(stall), .done(done), .rdata(rdata), .exc(exc),
    .exc_code(exc_code), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_be(mem_be), .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata)
  );

  typedef struct packed {
    logic        all;
    logic        stall;
    logic        done;
    logic        exc;
    logic [1:0]  code;
    logic [31:0] rdata;
    logic        req;
    logic        we;
    logic [31:0] addr;
    logic [3:0]  be;
    logic        chk_wd;
    logic [31:0] wd;
  } exp_t;

  exp_t expq[$];
  int n_tests = 0, n_fail = 0;
  int stall_run = 0, last_stall_run = 0, req_run = 0, last_req_run = 0;
  int done_run = 0, last_done_run = 0, n_done = 0;
  logic we_seen = 1'b0, req_seen = 1'b0;
  logic [31:0] cap_rdata = '0, cap_addr = '0, cap_wdata = '0;
  logic [3:0]  cap_be = '0;
  logic [1:0]  cap_code = '0;
  logic        cap_exc = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %08h, expected %08h", name, $time, act, exp);
    end
  endtask

  // ---- behavioural model ----
  function automatic int unsigned op_size(input logic [2:0] o);
    if (o == OP_LW || o == OP_SW) return 4;
    if (o == OP_LH || o == OP_LHU || o == OP_SH) return 2;
    return 1;
  endfunction

  function automatic logic op_is_st(input logic [2:0] o);
    return (o == OP_SW) || (o == OP_SH) || (o == OP_SB);
  endfunction

  function automatic logic [1:0] model_fault(input logic [2:0] o, input logic [31:0] a);
    if ((a % 32'(op_size(o))) != 0) return 2'd1;
    if (longint'(a) < longint'(TB_LO) || longint'(a) > longint'(TB_HI)) return 2'd2;
    return 2'd0;
  endfunction

  function automatic logic [3:0] model_be(input logic [2:0] o, input logic [31:0] a);
    int unsigned sz;
    sz = op_size(o);
    if (!op_is_st(o)) return 4'hf;
    return 4'(((1 << sz) - 1) << (a % 4));
  endfunction

  function automatic logic [31:0] model_wd(input logic [2:0] o, input logic [31:0] w);
    int unsigned sz;
    sz = op_size(o);
    if (sz == 4) return w;
    if (sz == 2) return 32'(w[15:0]) * 32'h0001_0001;
    return 32'(w[7:0]) * 32'h0101_0101;
  endfunction

  function automatic logic [31:0] model_ld(input logic [2:0] o, input logic [31:0] a,
                                           input logic [31:0] rw);
    int unsigned sz;
    logic [31:0] v, mask;
    sz = op_size(o);
    v = rw >> (8 * (a % 4));
    if (sz == 4) return v;
    mask = (sz == 2) ? 32'h0000_ffff : 32'h0000_00ff;
    v = v & mask;
    if ((o == OP_LH || o == OP_LB) && v[8*sz-1]) v = v | ~mask;
    return v;
  endfunction

  // ---- compare process: samples just after inputs change each cycle ----
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #1;
      if (expq.size() != 0) begin
        e = expq.pop_front();
        chk("stall", 32'(stall), 32'(e.stall));
        chk("done", 32'(done), 32'(e.done));
        chk("mem_req", 32'(mem_req), 32'(e.req));
        chk("mem_we", 32'(mem_we), 32'(e.we));
        if (e.done || e.all) begin
          chk("exc", 32'(exc), 32'(e.exc));
          chk("exc_code", 32'(exc_code), 32'(e.code));
          chk("rdata", rdata, e.rdata);
        end
        if (e.req || e.all) begin
          chk("mem_addr", mem_addr, e.addr);
          chk("mem_be", 32'(mem_be), 32'(e.be));
        end
        if ((e.req && e.chk_wd) || e.all) chk("mem_wdata", mem_wdata, e.wd);
      end
      if (stall) stall_run++;
      else begin if (stall_run != 0) last_stall_run = stall_run; stall_run = 0; end
      if (mem_req) begin req_run++; req_seen = 1'b1; cap_addr = mem_addr; cap_be = mem_be; cap_wdata = mem_wdata; end
      else begin if (req_run != 0) last_req_run = req_run; req_run = 0; end
      if (done) begin done_run++; n_done++; cap_rdata = rdata; cap_code = exc_code; cap_exc = exc; end
      else begin if (done_run != 0) last_done_run = done_run; done_run = 0; end
      if (mem_we) we_seen = 1'b1;
    end
  end

  // ---- stimulus ----
  task automatic cyc(input logic rst, input logic rv, input logic [2:0] o, input logic [31:0] a,
                     input logic [31:0] w, input logic ack, input logic [31:0] rw, input exp_t e);
    @(negedge clk);
    reset = rst; req_valid = rv; op = o; addr = a; wdata = w; mem_ack = ack; mem_rdata = rw;
    expq.push_back(e);
  endtask

  task automatic idle(input int n, input logic force_ack);
    for (int i = 0; i < n; i++)
      cyc(1'b0, 1'b0, 3'($urandom), $urandom, $urandom, force_ack | 1'($urandom & 1), $urandom, '0);
  endtask

  function automatic exp_t busy_e(input logic [2:0] o, input logic [31:0] a, input logic [31:0] w);
    exp_t e;
    e = '0;
    e.stall = 1'b1; e.req = 1'b1; e.we = op_is_st(o);
    e.addr = {a[31:2], 2'b00}; e.be = model_be(o, a);
    e.chk_wd = op_is_st(o); e.wd = model_wd(o, w);
    return e;
  endfunction

  // One full access: accept, BUSY until ack or timeout, DONE.
  task automatic access(input logic [2:0] o, input logic [31:0] a, input logic [31:0] w,
                        input int ack_dly, input logic [31:0] rw);
    exp_t e;
    logic [1:0] f;
    logic acked;
    int nb;
    f = model_fault(o, a);
    e = '0; e.stall = 1'b1;
    cyc(1'b0, 1'b1, o, a, w, 1'($urandom & 1), $urandom, e);
    if (f != 2'd0) begin
      e = '0; e.done = 1'b1; e.exc = 1'b1; e.code = f;
      cyc(1'b0, 1'b0, o, a, w, 1'($urandom & 1), $urandom, e);
    end else begin
      acked = ack_dly < int'(TB_TO);
      nb = acked ? ack_dly + 1 : int'(TB_TO);
      for (int i = 0; i < nb; i++)
        cyc(1'b0, 1'b1, o, a, w, acked && (i == ack_dly),
            (acked && (i == ack_dly)) ? rw : $urandom, busy_e(o, a, w));
      e = '0; e.done = 1'b1;
      if (acked) e.rdata = op_is_st(o) ? 32'h0 : model_ld(o, a, rw);
      else begin e.exc = 1'b1; e.code = 2'd3; end
      cyc(1'b0, 1'b0, o, a, w, 1'($urandom & 1), $urandom, e);
    end
  endtask

  initial begin
    exp_t e;
    int    nd;
    logic [31:0] a;
    reset = 1'b1; req_valid = 1'b0; op = '0; addr = '0; wdata = '0; mem_ack = 1'b0; mem_rdata = '0;
    e = '0; e.all = 1'b1;
    cyc(1'b1, 1'b0, '0, '0, '0, 1'b0, '0, e);
    cyc(1'b0, 1'b0, '0, '0, '0, 1'b0, '0, e);
    idle(2, 1'b0);

    access(OP_SW, 32'h0000_0104, 32'hDEADBEEF, 2, 32'h0);
    idle(2, 1'b0);
    chk("sw_be", 32'(cap_be), 32'h0000_000f);
    chk("sw_addr", cap_addr, 32'h0000_0104);
    chk("sw_stall_cycles", 32'(last_stall_run), 32'd4);
    chk("sw_done_cycles", 32'(last_done_run), 32'd1);
    chk("sw_exc", 32'(cap_exc), 32'h0);

    access(OP_SB, 32'h0000_0013, 32'h0000_00A5, 0, 32'h0);
    idle(2, 1'b0);
    chk("sb_be", 32'(cap_be), 32'h0000_0008);
    chk("sb_wdata", cap_wdata, 32'hA5A5A5A5);
    chk("sb_addr", cap_addr, 32'h0000_0010);

    access(OP_LH, 32'h0000_0022, 32'h0, 1, 32'h8001_7FFF);
    idle(2, 1'b0);
    chk("lh_rdata", cap_rdata, 32'hFFFF8001);
    access(OP_LHU, 32'h0000_0022, 32'h0, 0, 32'h8001_7FFF);
    idle(2, 1'b0);
    chk("lhu_rdata", cap_rdata, 32'h00008001);
    access(OP_LB, 32'h0000_0020, 32'h0, 0, 32'h8001_7FFF);
    idle(2, 1'b0);
    chk("lb_rdata", cap_rdata, 32'hFFFFFFFF);

    req_seen = 1'b0;
    access(OP_LW, 32'h0000_0102, 32'h0, 0, 32'h0);
    idle(2, 1'b0);
    chk("lw_mis_code", 32'(cap_code), 32'd1);
    chk("lw_mis_exc", 32'(cap_exc), 32'd1);
    chk("lw_mis_no_req", 32'(req_seen), 32'd0);

    we_seen = 1'b0;
    access(OP_SW, 32'h0000_3000, 32'h1234_5678, 0, 32'h0);
    idle(2, 1'b0);
    chk("sw_range_code", 32'(cap_code), 32'd2);
    chk("sw_range_no_we", 32'(we_seen), 32'd0);

    access(OP_LH, 32'h0000_3001, 32'h0, 0, 32'h0);
    idle(2, 1'b0);
    chk("mis_over_range_code", 32'(cap_code), 32'd1);

    access(OP_LW, 32'h0000_0200, 32'h0, 99, 32'h0);
    idle(3, 1'b1);
    chk("to_req_cycles", 32'(last_req_run), 32'd4);
    chk("to_code", 32'(cap_code), 32'd3);

    // Reset lands on the second BUSY cycle of a load.
    nd = n_done;
    e = '0; e.stall = 1'b1;
    cyc(1'b0, 1'b1, OP_LW, 32'h0000_0300, '0, 1'b0, '0, e);
    cyc(1'b0, 1'b1, OP_LW, 32'h0000_0300, '0, 1'b0, '0, busy_e(OP_LW, 32'h300, '0));
    cyc(1'b1, 1'b1, OP_LW, 32'h0000_0300, '0, 1'b0, '0, busy_e(OP_LW, 32'h300, '0));
    e = '0; e.all = 1'b1;
    cyc(1'b0, 1'b0, OP_LW, 32'h0000_0300, '0, 1'b0, '0, e);
    idle(2, 1'b0);
    chk("rst_no_done", 32'(n_done - nd), 32'd0);
    access(OP_LBU, 32'h0000_0001, 32'h0, 1, 32'h0000_F000);
    idle(2, 1'b0);
    chk("lbu_rdata", cap_rdata, 32'h000000F0);

    for (int k = 0; k < 300; k++) begin
      case ($urandom % 8)
        0:       a = 32'h0000_3000 + ($urandom % 64);
        1:       a = $urandom;
        2:       a = 32'h0000_2ff0 + ($urandom % 16);
        default: a = $urandom % 32'h0000_3000;
      endcase
      access(3'($urandom), a, $urandom, int'($urandom % 6), $urandom);
      idle(int'($urandom % 3), 1'b0);
    end

    idle(2, 1'b0);
    @(negedge clk);
    #2;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
